// File: rtl/tour_pkg.sv
// Shared types and constants for the knight's-tour command replayer.
package tour_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StVert,
    StHoldV,
    StHorz,
    StHoldH
  } tour_state_e;

  localparam logic [3:0] OpMove    = 4'h2;
  localparam logic [3:0] OpFanfare = 4'h3;

  localparam logic [7:0] HeadNorth = 8'h00;
  localparam logic [7:0] HeadWest  = 8'h3F;
  localparam logic [7:0] HeadSouth = 8'h7F;
  localparam logic [7:0] HeadEast  = 8'hBF;

  localparam logic [7:0] RespTour = 8'h5A;
  localparam logic [7:0] RespIdle = 8'hA5;

  localparam int unsigned NumMovesDefault = 24;

endpackage

// File: rtl/tour_move_decode.sv
// Maps a one-hot knight move to signed (dx, dy); valid_o is low for zero or multi-hot input.
module tour_move_decode (
  input  logic              [7:0] move_i,
  output logic signed       [2:0] dx_o,
  output logic signed       [2:0] dy_o,
  output logic                    valid_o
);

  always_comb begin
    dx_o    = 3'sd0;
    dy_o    = 3'sd0;
    valid_o = 1'b1;
    unique case (move_i)
      8'h01: begin dx_o = -3'sd1; dy_o =  3'sd2; end
      8'h02: begin dx_o =  3'sd1; dy_o =  3'sd2; end
      8'h04: begin dx_o = -3'sd2; dy_o =  3'sd1; end
      8'h08: begin dx_o = -3'sd2; dy_o = -3'sd1; end
      8'h10: begin dx_o = -3'sd1; dy_o = -3'sd2; end
      8'h20: begin dx_o =  3'sd1; dy_o = -3'sd2; end
      8'h40: begin dx_o =  3'sd2; dy_o =  3'sd1; end
      8'h80: begin dx_o =  3'sd2; dy_o = -3'sd1; end
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/tour_cmd.sv
// Replays a solved knight's tour as vertical/horizontal move commands, else passes UART commands.
// Optional TOUR_CMD_FANFARE_EN selects the fanfare opcode for horizontal legs.
module tour_cmd
  import tour_pkg::*;
#(
  parameter int unsigned NUM_MOVES = NumMovesDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic [7:0]  resp
);

`ifdef TOUR_CMD_FANFARE_EN
  localparam logic [3:0] HorzOp = OpFanfare;
`else
  localparam logic [3:0] HorzOp = OpMove;
`endif

  localparam logic [4:0] LastIdx = 5'(NUM_MOVES - 1);

  tour_state_e state_q, state_d;
  logic [4:0]  mv_indx_q, mv_indx_d;

  logic signed [2:0] dx, dy;
  logic              move_ok;
  logic [2:0]        adx, ady;
  logic [15:0]       vert_cmd, horz_cmd;
  logic              last_move;

  tour_move_decode u_decode (
    .move_i  (move),
    .dx_o    (dx),
    .dy_o    (dy),
    .valid_o (move_ok)
  );

  assign adx = dx[2] ? unsigned'(-dx) : unsigned'(dx);
  assign ady = dy[2] ? unsigned'(-dy) : unsigned'(dy);

  // Invalid moves still step through both legs, just with a null command.
  assign vert_cmd = move_ok ? {OpMove, (dy[2] ? HeadSouth : HeadNorth), 1'b0, ady} : 16'h0000;
  assign horz_cmd = move_ok ? {HorzOp, (dx[2] ? HeadWest : HeadEast), 1'b0, adx} : 16'h0000;

  assign last_move = (mv_indx_q == LastIdx);
  assign mv_indx   = mv_indx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      mv_indx_q <= '0;
    end else begin
      state_q   <= state_d;
      mv_indx_q <= mv_indx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mv_indx_d = mv_indx_q;
    cmd       = cmd_UART;
    cmd_rdy   = 1'b0;
    resp      = RespTour;
    unique case (state_q)
      StIdle: begin
        cmd_rdy = cmd_rdy_UART;
        resp    = RespIdle;
        if (start_tour) begin
          mv_indx_d = '0;
          state_d   = StVert;
        end
      end
      StVert: begin
        cmd     = vert_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_d = StHoldV;
      end
      StHoldV: begin
        cmd = vert_cmd;
        if (send_resp) state_d = StHorz;
      end
      StHorz: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_d = StHoldH;
      end
      StHoldH: begin
        cmd = horz_cmd;
        if (last_move) resp = RespIdle;
        if (send_resp) begin
          if (last_move) begin
            state_d = StIdle;
          end else begin
            mv_indx_d = mv_indx_q + 5'd1;
            state_d   = StVert;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_tour_cmd.sv
// Directed bench for tour_cmd: vector table replayed over a full tour plus reset/ignore sequences.
module tb_tour_cmd;

`ifdef TOUR_CMD_FANFARE_EN
  localparam logic [3:0] HOP = 4'h3;
`else
  localparam logic [3:0] HOP = 4'h2;
`endif

  logic        clk;
  logic        rst_n;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic [7:0]  resp;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0]  mv;
    logic [15:0] vcmd;
    logic [15:0] hcmd;
  } vec_t;

  vec_t       vecs[10];
  logic [7:0] tour_moves[24];

  tour_cmd dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_tour   (start_tour),
    .move         (move),
    .mv_indx      (mv_indx),
    .cmd_UART     (cmd_UART),
    .cmd_rdy_UART (cmd_rdy_UART),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .send_resp    (send_resp),
    .cmd          (cmd),
    .cmd_rdy      (cmd_rdy),
    .resp         (resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The solver presents the move selected by mv_indx.
  always_comb move = (mv_indx < 5'd24) ? tour_moves[mv_indx] : 8'h00;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic pulse_send();
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
  endtask

  task automatic pulse_start();
    start_tour = 1'b1;
    tick();
    start_tour = 1'b0;
  endtask

  initial begin
    // Move 0x01 is dx=-1 (west); 0x08 is dx=-2 (west), dy=-1 (south).
    vecs[0] = '{8'h01, 16'h2002, {HOP, 12'h3F1}};
    vecs[1] = '{8'h02, 16'h2002, {HOP, 12'hBF1}};
    vecs[2] = '{8'h04, 16'h2001, {HOP, 12'h3F2}};
    vecs[3] = '{8'h08, 16'h27F1, {HOP, 12'h3F2}};
    vecs[4] = '{8'h10, 16'h27F2, {HOP, 12'h3F1}};
    vecs[5] = '{8'h20, 16'h27F2, {HOP, 12'hBF1}};
    vecs[6] = '{8'h40, 16'h2001, {HOP, 12'hBF2}};
    vecs[7] = '{8'h80, 16'h27F1, {HOP, 12'hBF2}};
    vecs[8] = '{8'h03, 16'h0000, 16'h0000};
    vecs[9] = '{8'h00, 16'h0000, 16'h0000};
    for (int k = 0; k < 24; k++) tour_moves[k] = vecs[k % 10].mv;

    rst_n        = 1'b0;
    start_tour   = 1'b0;
    clr_cmd_rdy  = 1'b0;
    send_resp    = 1'b0;
    cmd_UART     = 16'h2003;
    cmd_rdy_UART = 1'b1;
    #2;
    chk("rst_mv_indx", 16'(mv_indx), 16'h0000);
    chk("rst_cmd_rdy", 16'(cmd_rdy), 16'h0001);
    chk("rst_resp", 16'(resp), 16'h00A5);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("idle_cmd", cmd, 16'h2003);
    chk("idle_cmd_rdy", 16'(cmd_rdy), 16'h0001);
    chk("idle_resp", 16'(resp), 16'h00A5);
    cmd_rdy_UART = 1'b0;
    cmd_UART     = 16'h1234;
    pulse_send();
    chk("idle_cmd2", cmd, 16'h1234);
    chk("idle_cmd_rdy2", 16'(cmd_rdy), 16'h0000);

    // Full tour, one table entry per move.
    pulse_start();
    for (int k = 0; k < 24; k++) begin
      vec_t e;
      e = vecs[k % 10];
      chk("vert_mv_indx", 16'(mv_indx), 16'(k));
      chk("vert_cmd", cmd, e.vcmd);
      chk("vert_cmd_rdy", 16'(cmd_rdy), 16'h0001);
      chk("vert_resp", 16'(resp), 16'h005A);
      pulse_send();
      chk("vert_ign_send", 16'(cmd_rdy), 16'h0001);
      pulse_clr();
      chk("holdv_cmd", cmd, e.vcmd);
      chk("holdv_cmd_rdy", 16'(cmd_rdy), 16'h0000);
      chk("holdv_resp", 16'(resp), 16'h005A);
      pulse_clr();
      chk("holdv_ign_clr", 16'(cmd_rdy), 16'h0000);
      pulse_send();
      chk("horz_cmd", cmd, e.hcmd);
      chk("horz_cmd_rdy", 16'(cmd_rdy), 16'h0001);
      chk("horz_resp", 16'(resp), 16'h005A);
      if (k == 2) begin
        start_tour   = 1'b1;
        cmd_rdy_UART = 1'b1;
        tick();
        start_tour   = 1'b0;
        cmd_rdy_UART = 1'b0;
        chk("horz_ign_cmd", cmd, e.hcmd);
        chk("horz_ign_cmd_rdy", 16'(cmd_rdy), 16'h0001);
        chk("horz_ign_mv_indx", 16'(mv_indx), 16'(k));
      end
      pulse_clr();
      chk("holdh_cmd", cmd, e.hcmd);
      chk("holdh_cmd_rdy", 16'(cmd_rdy), 16'h0000);
      chk("holdh_resp", 16'(resp), (k == 23) ? 16'h00A5 : 16'h005A);
      chk("holdh_mv_indx", 16'(mv_indx), 16'(k));
      pulse_send();
    end
    chk("end_idle_cmd", cmd, 16'h1234);
    chk("end_idle_cmd_rdy", 16'(cmd_rdy), 16'h0000);
    chk("end_idle_resp", 16'(resp), 16'h00A5);
    cmd_rdy_UART = 1'b1;
    #1;
    chk("end_idle_cmd_rdy_uart", 16'(cmd_rdy), 16'h0001);
    cmd_rdy_UART = 1'b0;

    // Restart clears mv_indx; reset mid-tour in HOLD_H at move 7.
    pulse_start();
    chk("restart_mv_indx", 16'(mv_indx), 16'h0000);
    chk("restart_cmd", cmd, vecs[0].vcmd);
    for (int k = 0; k < 7; k++) begin
      pulse_clr();
      pulse_send();
      pulse_clr();
      pulse_send();
    end
    pulse_clr();
    pulse_send();
    pulse_clr();
    chk("pre_rst_mv_indx", 16'(mv_indx), 16'h0007);
    chk("pre_rst_cmd_rdy", 16'(cmd_rdy), 16'h0000);
    cmd_rdy_UART = 1'b1;
    cmd_UART     = 16'hC0DE;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_mv_indx", 16'(mv_indx), 16'h0000);
    chk("mid_rst_cmd_rdy", 16'(cmd_rdy), 16'h0001);
    chk("mid_rst_cmd", cmd, 16'hC0DE);
    chk("mid_rst_resp", 16'(resp), 16'h00A5);
    tick();
    rst_n = 1'b1;
    pulse_send();
    chk("post_rst_idle", 16'(cmd_rdy), 16'h0001);
    cmd_rdy_UART = 1'b0;
    pulse_start();
    chk("post_rst_start_cmd", cmd, vecs[0].vcmd);
    chk("post_rst_start_mv", 16'(mv_indx), 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
